// File: rtl/btb_sa_if.sv
// btb_sa_if
// Bundles the lookup, response, update and flush signals of btb_sa_module.
//   master : drives lookup/allocate/mispredict/clear/flush requests,
//            receives lookup responses and flush-busy status
//   slave  : the BTB itself
// Signal names keep the i_/o_ direction prefixes as seen from the BTB.
interface btb_sa_if #(
    parameter int PC_WIDTH = 32,
    parameter int SETS     = 8,
    parameter int WAYS     = 4
);
    localparam int SET_BITS = $clog2(SETS);
    localparam int WAY_BITS = $clog2(WAYS);

    logic                i_lkp_vld;
    logic [PC_WIDTH-1:0] i_lkp_pc;
    logic                o_rsp_vld;
    logic                o_rsp_hit;
    logic [SET_BITS-1:0] o_rsp_set;
    logic [WAY_BITS-1:0] o_rsp_way;
    logic [PC_WIDTH-1:0] o_rsp_taddr;
    logic [3:0]          o_rsp_offset;
    logic                o_rsp_type;
    logic                i_new_vld;
    logic [PC_WIDTH-1:0] i_new_pc;
    logic [PC_WIDTH-1:0] i_new_taddr;
    logic                i_new_type;
    logic                i_mis_vld;
    logic [SET_BITS-1:0] i_mis_set;
    logic [WAY_BITS-1:0] i_mis_way;
    logic [PC_WIDTH-1:0] i_mis_taddr;
    logic                i_clr_vld;
    logic [SET_BITS-1:0] i_clr_set;
    logic [WAY_BITS-1:0] i_clr_way;
    logic                i_flush;
    logic                o_flush_busy;

    modport master (
        output i_lkp_vld, i_lkp_pc,
        input  o_rsp_vld, o_rsp_hit, o_rsp_set, o_rsp_way,
               o_rsp_taddr, o_rsp_offset, o_rsp_type,
        output i_new_vld, i_new_pc, i_new_taddr, i_new_type,
        output i_mis_vld, i_mis_set, i_mis_way, i_mis_taddr,
        output i_clr_vld, i_clr_set, i_clr_way,
        output i_flush,
        input  o_flush_busy
    );

    modport slave (
        input  i_lkp_vld, i_lkp_pc,
        output o_rsp_vld, o_rsp_hit, o_rsp_set, o_rsp_way,
               o_rsp_taddr, o_rsp_offset, o_rsp_type,
        input  i_new_vld, i_new_pc, i_new_taddr, i_new_type,
        input  i_mis_vld, i_mis_set, i_mis_way, i_mis_taddr,
        input  i_clr_vld, i_clr_set, i_clr_way,
        input  i_flush,
        output o_flush_busy
    );
endinterface

// File: rtl/btb_sa_module.sv
// btb_sa_module
// Set-associative branch target buffer with a registered one-cycle lookup,
// in-place refresh of present branches, per-set round-robin replacement and
// a one-set-per-cycle whole-table flush sequencer.
// Ports:
//   clk    : core clock
//   rst_n  : asynchronous active-low reset (valids, pointers, FSM, outputs)
//   bus    : btb_sa_if.slave - lookup/response, allocate, mispredict,
//            clear and flush signals
// Optional feature macro: BTB_SA_BYPASS_EN
//   defined   - same-cycle allocate/mispredict/clear are forwarded into the
//               lookup response (response reflects post-update table)
//   undefined - the response reflects the table before that cycle's updates
module btb_sa_module #(
    parameter int PC_WIDTH = 32,
    parameter int SETS     = 8,
    parameter int WAYS     = 4
) (
    input logic     clk,
    input logic     rst_n,
    btb_sa_if.slave bus
);
    localparam int SET_BITS = $clog2(SETS);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int TAG_BITS = PC_WIDTH - 4 - SET_BITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Table storage: valid bits and pointers are reset, payload is not.
    logic [WAYS-1:0]     r_valid  [SETS];
    logic [WAY_BITS-1:0] r_rr     [SETS];
    logic [TAG_BITS-1:0] r_tag    [SETS][WAYS];
    logic [PC_WIDTH-1:0] r_taddr  [SETS][WAYS];
    logic [3:0]          r_offset [SETS][WAYS];
    logic                r_type   [SETS][WAYS];

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SET_BITS-1:0] r_flush_cnt;
    logic [SET_BITS-1:0] w_flush_cnt_nxt;
    logic                r_flush_busy;

    // Address split of the three PC-carrying requests.
    logic [SET_BITS-1:0] w_lkp_set;
    logic [TAG_BITS-1:0] w_lkp_tag;
    logic [SET_BITS-1:0] w_new_set;
    logic [TAG_BITS-1:0] w_new_tag;

    assign w_lkp_set = bus.i_lkp_pc[4 +: SET_BITS];
    assign w_lkp_tag = bus.i_lkp_pc[PC_WIDTH-1 -: TAG_BITS];
    assign w_new_set = bus.i_new_pc[4 +: SET_BITS];
    assign w_new_tag = bus.i_new_pc[PC_WIDTH-1 -: TAG_BITS];

    logic                w_upd_en;
    logic                w_new_match;
    logic [WAY_BITS-1:0] w_new_match_way;
    logic                w_new_free;
    logic [WAY_BITS-1:0] w_new_free_way;
    logic [WAY_BITS-1:0] w_new_way;
    logic                w_new_use_rr;
    logic                w_new_en;
    logic                w_mis_en;
    logic                w_clr_en;

    logic                w_hit;
    logic [WAY_BITS-1:0] w_hit_way;
    logic [PC_WIDTH-1:0] w_hit_taddr;
    logic [3:0]          w_hit_offset;
    logic                w_hit_type;

    // Updates are only honoured outside the flush sequence.
    assign w_upd_en = (r_state == ST_IDLE);

    // Allocate victim selection: present tag, else lowest invalid way, else round-robin.
    always_comb begin
        w_new_match     = 1'b0;
        w_new_match_way = '0;
        w_new_free      = 1'b0;
        w_new_free_way  = '0;
        // Descending scan so the lowest-index qualifying way is the one kept.
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_new_match_way = (r_valid[w_new_set][w] && (r_tag[w_new_set][w] == w_new_tag))
                              ? WAY_BITS'(w) : w_new_match_way;
            w_new_match     = w_new_match | (r_valid[w_new_set][w] && (r_tag[w_new_set][w] == w_new_tag));
            w_new_free_way  = (!r_valid[w_new_set][w]) ? WAY_BITS'(w) : w_new_free_way;
            w_new_free      = w_new_free | !r_valid[w_new_set][w];
        end
        w_new_use_rr = !w_new_match && !w_new_free;
        w_new_way    = w_new_match ? w_new_match_way :
                       (w_new_free ? w_new_free_way : r_rr[w_new_set]);
    end

    // Collision resolution on a shared entry: clear > allocate > mispredict.
    always_comb begin
        w_clr_en = w_upd_en && bus.i_clr_vld;
        w_new_en = w_upd_en && bus.i_new_vld &&
                   !(w_clr_en && (bus.i_clr_set == w_new_set) && (bus.i_clr_way == w_new_way));
        w_mis_en = w_upd_en && bus.i_mis_vld && r_valid[bus.i_mis_set][bus.i_mis_way] &&
                   !(w_clr_en && (bus.i_clr_set == bus.i_mis_set) && (bus.i_clr_way == bus.i_mis_way)) &&
                   !(w_new_en && (w_new_set == bus.i_mis_set) && (w_new_way == bus.i_mis_way));
    end

    // Flush sequencer next-state: walk every set once, then return to idle.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_flush) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                w_flush_cnt_nxt = r_flush_cnt + SET_BITS'(1);
                if (r_flush_cnt == SET_BITS'(SETS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    // Lookup compare across all ways of the indexed set, with optional forwarding.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_hit_way = (r_valid[w_lkp_set][w] && (r_tag[w_lkp_set][w] == w_lkp_tag))
                        ? WAY_BITS'(w) : w_hit_way;
            w_hit     = w_hit | (r_valid[w_lkp_set][w] && (r_tag[w_lkp_set][w] == w_lkp_tag));
        end
        w_hit_taddr  = r_taddr[w_lkp_set][w_hit_way];
        w_hit_offset = r_offset[w_lkp_set][w_hit_way];
        w_hit_type   = r_type[w_lkp_set][w_hit_way];
`ifdef BTB_SA_BYPASS_EN
        // Mispredict rewrites the target of the entry being hit.
        if (w_hit && w_mis_en && (bus.i_mis_set == w_lkp_set) && (bus.i_mis_way == w_hit_way)) begin
            w_hit_taddr = bus.i_mis_taddr;
        end else begin
            w_hit_taddr = w_hit_taddr;
        end
        // Allocate either creates/refreshes the looked-up tag or evicts the hit way.
        if (w_new_en && (w_new_set == w_lkp_set) && (w_new_tag == w_lkp_tag)) begin
            w_hit        = 1'b1;
            w_hit_way    = w_new_way;
            w_hit_taddr  = bus.i_new_taddr;
            w_hit_offset = bus.i_new_pc[3:0];
            w_hit_type   = bus.i_new_type;
        end else if (w_new_en && (w_new_set == w_lkp_set) && (w_new_way == w_hit_way)) begin
            w_hit = 1'b0;
        end else begin
            w_hit = w_hit;
        end
        // A same-cycle clear of the resulting entry turns the hit into a miss.
        if (w_clr_en && (bus.i_clr_set == w_lkp_set) && (bus.i_clr_way == w_hit_way)) begin
            w_hit = 1'b0;
        end else begin
            w_hit = w_hit;
        end
`endif
    end

    // Valid bits, round-robin pointers and flush sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
            r_state      <= ST_IDLE;
            r_flush_cnt  <= '0;
            r_flush_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_flush_busy <= (w_state_nxt == ST_FLUSH);
            if (r_state == ST_FLUSH) begin
                r_valid[r_flush_cnt] <= '0;
                r_rr[r_flush_cnt]    <= '0;
            end else begin
                // Clear and allocate never target the same entry here (resolved above).
                if (w_new_en) begin
                    r_valid[w_new_set][w_new_way] <= 1'b1;
                    if (w_new_use_rr) begin
                        r_rr[w_new_set] <= r_rr[w_new_set] + WAY_BITS'(1);
                    end
                end
                if (w_clr_en) begin
                    r_valid[bus.i_clr_set][bus.i_clr_way] <= 1'b0;
                end
            end
        end
    end

    // Entry payload: tag and data are left unreset, guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (w_new_en) begin
            r_tag[w_new_set][w_new_way]    <= w_new_tag;
            r_taddr[w_new_set][w_new_way]  <= bus.i_new_taddr;
            r_offset[w_new_set][w_new_way] <= bus.i_new_pc[3:0];
            r_type[w_new_set][w_new_way]   <= bus.i_new_type;
        end
        if (w_mis_en) begin
            r_taddr[bus.i_mis_set][bus.i_mis_way] <= bus.i_mis_taddr;
        end
    end

    // Registered lookup response; misses and flush-time lookups return zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_rsp_vld    <= 1'b0;
            bus.o_rsp_hit    <= 1'b0;
            bus.o_rsp_set    <= '0;
            bus.o_rsp_way    <= '0;
            bus.o_rsp_taddr  <= '0;
            bus.o_rsp_offset <= 4'h0;
            bus.o_rsp_type   <= 1'b0;
        end else begin
            bus.o_rsp_vld <= bus.i_lkp_vld;
            if (bus.i_lkp_vld && w_hit && (r_state == ST_IDLE)) begin
                bus.o_rsp_hit    <= 1'b1;
                bus.o_rsp_set    <= w_lkp_set;
                bus.o_rsp_way    <= w_hit_way;
                bus.o_rsp_taddr  <= w_hit_taddr;
                bus.o_rsp_offset <= w_hit_offset;
                bus.o_rsp_type   <= w_hit_type;
            end else begin
                bus.o_rsp_hit    <= 1'b0;
                bus.o_rsp_set    <= '0;
                bus.o_rsp_way    <= '0;
                bus.o_rsp_taddr  <= '0;
                bus.o_rsp_offset <= 4'h0;
                bus.o_rsp_type   <= 1'b0;
            end
        end
    end

    assign bus.o_flush_busy = r_flush_busy;

endmodule

// File: tb/tb_btb_sa_module.sv
// tb_btb_sa_module
// Directed scenarios followed by randomized traffic, every cycle compared
// against a table-level reference model of the BTB.
module tb_btb_sa_module;
    localparam int PW = 32;
    localparam int NS = 8;
    localparam int NW = 4;

    logic clk;
    logic rst_n;

    btb_sa_if #(.PC_WIDTH(PW), .SETS(NS), .WAYS(NW)) bus ();

    btb_sa_module #(.PC_WIDTH(PW), .SETS(NS), .WAYS(NW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference table
    bit          m_valid [NS][NW];
    logic [24:0] m_tag   [NS][NW];
    logic [31:0] m_taddr [NS][NW];
    logic [3:0]  m_off   [NS][NW];
    bit          m_type  [NS][NW];
    int          m_rr    [NS];
    bit          m_flushing;
    int          m_fcnt;

    // Expected outputs after the most recent edge
    logic        e_vld, e_hit, e_type, e_busy;
    logic [2:0]  e_set;
    logic [1:0]  e_way;
    logic [31:0] e_taddr;
    logic [3:0]  e_off;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
        end
        m_flushing = 1'b0;
        m_fcnt = 0;
        e_vld = 1'b0; e_hit = 1'b0; e_type = 1'b0; e_busy = 1'b0;
        e_set = 3'd0; e_way = 2'd0; e_taddr = 32'd0; e_off = 4'd0;
    endfunction

    // Look a PC up in the current model table.
    function automatic void model_lookup(input logic [31:0] pc);
        int s;
        s = int'(pc[6:4]);
        e_hit = 1'b0; e_set = 3'd0; e_way = 2'd0; e_taddr = 32'd0; e_off = 4'd0; e_type = 1'b0;
        for (int w = NW - 1; w >= 0; w--) begin
            if (m_valid[s][w] && m_tag[s][w] == pc[31:7]) begin
                e_hit = 1'b1; e_set = pc[6:4]; e_way = 2'(w);
                e_taddr = m_taddr[s][w]; e_off = m_off[s][w]; e_type = m_type[s][w];
            end
        end
    endfunction

    // Apply one clock edge worth of requests to the model.
    function automatic void model_step();
        logic        lv, nv, mv, cv, fl, nt;
        logic [31:0] lpc, npc, nta, mta;
        int ms, mw, cs, cw, s, tw;
        bit was_flushing, userr, drop, mis_ok;
        lv = bus.i_lkp_vld; lpc = bus.i_lkp_pc;
        nv = bus.i_new_vld; npc = bus.i_new_pc; nta = bus.i_new_taddr; nt = bus.i_new_type;
        mv = bus.i_mis_vld; ms = int'(bus.i_mis_set); mw = int'(bus.i_mis_way); mta = bus.i_mis_taddr;
        cv = bus.i_clr_vld; cs = int'(bus.i_clr_set); cw = int'(bus.i_clr_way);
        fl = bus.i_flush;
        was_flushing = m_flushing;
        if (!was_flushing && lv) model_lookup(lpc);
        else model_lookup(32'h0000_0000 | 32'h0);
        if (!(!was_flushing && lv)) begin
            e_hit = 1'b0; e_set = 3'd0; e_way = 2'd0; e_taddr = 32'd0; e_off = 4'd0; e_type = 1'b0;
        end
        if (was_flushing) begin
            for (int w = 0; w < NW; w++) m_valid[m_fcnt][w] = 1'b0;
            m_rr[m_fcnt] = 0;
            m_fcnt++;
            if (m_fcnt == NS) m_flushing = 1'b0;
        end else begin
            s = int'(npc[6:4]);
            tw = -1;
            for (int w = 0; w < NW; w++)
                if (tw < 0 && m_valid[s][w] && m_tag[s][w] == npc[31:7]) tw = w;
            for (int w = 0; w < NW; w++)
                if (tw < 0 && !m_valid[s][w]) tw = w;
            userr = 1'b0;
            if (tw < 0) begin tw = m_rr[s]; userr = 1'b1; end
            drop   = cv && cs == s && cw == tw;
            mis_ok = mv && m_valid[ms][mw] && !(cv && cs == ms && cw == mw) &&
                     !(nv && !drop && s == ms && tw == mw);
            if (nv && !drop) begin
                m_valid[s][tw] = 1'b1; m_tag[s][tw] = npc[31:7]; m_taddr[s][tw] = nta;
                m_off[s][tw] = npc[3:0]; m_type[s][tw] = nt;
                if (userr) m_rr[s] = (m_rr[s] + 1) % NW;
            end
            if (mis_ok) m_taddr[ms][mw] = mta;
            if (cv) m_valid[cs][cw] = 1'b0;
            if (fl) begin m_flushing = 1'b1; m_fcnt = 0; end
`ifdef BTB_SA_BYPASS_EN
            if (lv) model_lookup(lpc);
`endif
        end
        e_vld = lv;
        e_busy = m_flushing;
    endfunction

    task automatic compare_all();
        check_eq("rsp_vld", 64'(bus.o_rsp_vld), 64'(e_vld));
        check_eq("rsp_hit", 64'(bus.o_rsp_hit), 64'(e_hit));
        check_eq("rsp_set", 64'(bus.o_rsp_set), 64'(e_set));
        check_eq("rsp_way", 64'(bus.o_rsp_way), 64'(e_way));
        check_eq("rsp_taddr", 64'(bus.o_rsp_taddr), 64'(e_taddr));
        check_eq("rsp_offset", 64'(bus.o_rsp_offset), 64'(e_off));
        check_eq("rsp_type", 64'(bus.o_rsp_type), 64'(e_type));
        check_eq("flush_busy", 64'(bus.o_flush_busy), 64'(e_busy));
    endtask

    task automatic idle_inputs();
        bus.i_lkp_vld = 1'b0; bus.i_lkp_pc = 32'd0;
        bus.i_new_vld = 1'b0; bus.i_new_pc = 32'd0; bus.i_new_taddr = 32'd0; bus.i_new_type = 1'b0;
        bus.i_mis_vld = 1'b0; bus.i_mis_set = 3'd0; bus.i_mis_way = 2'd0; bus.i_mis_taddr = 32'd0;
        bus.i_clr_vld = 1'b0; bus.i_clr_set = 3'd0; bus.i_clr_way = 2'd0;
        bus.i_flush = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [31:0] ta, input logic ty);
        bus.i_new_vld = 1'b1; bus.i_new_pc = pc; bus.i_new_taddr = ta; bus.i_new_type = ty;
        cycle();
        bus.i_new_vld = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        bus.i_lkp_vld = 1'b1; bus.i_lkp_pc = pc;
        cycle();
        bus.i_lkp_vld = 1'b0;
    endtask

    initial begin
        logic [31:0] rp;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_eq("reset_vld", 64'(bus.o_rsp_vld), 64'd0);
        check_eq("reset_busy", 64'(bus.o_flush_busy), 64'd0);
        check_eq("reset_taddr", 64'(bus.o_rsp_taddr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lookup into an empty table
        do_lookup(32'h0000_1000);
        check_eq("empty_vld", 64'(bus.o_rsp_vld), 64'd1);
        check_eq("empty_hit", 64'(bus.o_rsp_hit), 64'd0);
        check_eq("empty_taddr", 64'(bus.o_rsp_taddr), 64'd0);

        // Allocate then lookup two cycles later
        do_alloc(32'h0000_1004, 32'h0000_2000, 1'b1);
        cycle();
        do_lookup(32'h0000_1000);
        check_eq("alloc_hit", 64'(bus.o_rsp_hit), 64'd1);
        check_eq("alloc_taddr", 64'(bus.o_rsp_taddr), 64'h2000);
        check_eq("alloc_offset", 64'(bus.o_rsp_offset), 64'd4);
        check_eq("alloc_type", 64'(bus.o_rsp_type), 64'd1);
        check_eq("alloc_way", 64'(bus.o_rsp_way), 64'd0);

        // Mispredict one entry while clearing another in the same set
        do_alloc(32'h0000_1084, 32'h0000_2100, 1'b0);
        bus.i_mis_vld = 1'b1; bus.i_mis_set = 3'd0; bus.i_mis_way = 2'd0; bus.i_mis_taddr = 32'h0000_3000;
        bus.i_clr_vld = 1'b1; bus.i_clr_set = 3'd0; bus.i_clr_way = 2'd1;
        cycle();
        idle_inputs();
        do_lookup(32'h0000_1000);
        check_eq("mis_taddr", 64'(bus.o_rsp_taddr), 64'h3000);
        check_eq("mis_offset", 64'(bus.o_rsp_offset), 64'd4);
        do_lookup(32'h0000_1080);
        check_eq("clr_hit", 64'(bus.o_rsp_hit), 64'd0);

        // Fill set 0, then force round-robin replacement and in-place refresh
        do_alloc(32'h0000_1080, 32'h0000_A001, 1'b0);
        do_alloc(32'h0000_1100, 32'h0000_A002, 1'b0);
        do_alloc(32'h0000_1180, 32'h0000_A003, 1'b0);
        do_alloc(32'h0000_1200, 32'h0000_B000, 1'b0);
        do_alloc(32'h0000_1280, 32'h0000_B001, 1'b0);
        do_alloc(32'h0000_1300, 32'h0000_B002, 1'b1);
        do_alloc(32'h0000_1288, 32'h0000_C001, 1'b1);
        do_alloc(32'h0000_1380, 32'h0000_B003, 1'b0);
        do_lookup(32'h0000_1200);
        check_eq("rr_way0", 64'(bus.o_rsp_way), 64'd0);
        do_lookup(32'h0000_1280);
        check_eq("refresh_way", 64'(bus.o_rsp_way), 64'd1);
        check_eq("refresh_taddr", 64'(bus.o_rsp_taddr), 64'hC001);
        check_eq("refresh_offset", 64'(bus.o_rsp_offset), 64'd8);
        do_lookup(32'h0000_1300);
        check_eq("rr_way2", 64'(bus.o_rsp_way), 64'd2);
        do_lookup(32'h0000_1380);
        check_eq("rr_way3_nomove", 64'(bus.o_rsp_way), 64'd3);
        do_lookup(32'h0000_1180);
        check_eq("evicted_hit", 64'(bus.o_rsp_hit), 64'd0);
        do_lookup(32'h0000_1000);
        check_eq("evicted2_hit", 64'(bus.o_rsp_hit), 64'd0);

        // Whole-table flush with allocates offered while busy
        bus.i_flush = 1'b1;
        cycle();
        bus.i_flush = 1'b0;
        check_eq("flush_busy_1", 64'(bus.o_flush_busy), 64'd1);
        bus.i_new_vld = 1'b1; bus.i_new_pc = 32'h0000_1000; bus.i_new_taddr = 32'h0000_5555;
        for (int i = 2; i <= 8; i++) begin
            bus.i_lkp_vld = 1'b1; bus.i_lkp_pc = 32'h0000_1300;
            cycle();
            check_eq("flush_busy_n", 64'(bus.o_flush_busy), 64'd1);
            check_eq("flush_lkp_hit", 64'(bus.o_rsp_hit), 64'd0);
        end
        cycle();
        check_eq("flush_done", 64'(bus.o_flush_busy), 64'd0);
        idle_inputs();
        do_lookup(32'h0000_1000);
        check_eq("post_flush_hit", 64'(bus.o_rsp_hit), 64'd0);
        do_lookup(32'h0000_1380);
        check_eq("post_flush_hit2", 64'(bus.o_rsp_hit), 64'd0);

        // Reset asserted in the middle of a flush
        bus.i_flush = 1'b1;
        cycle();
        bus.i_flush = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check_eq("midflush_rst_busy", 64'(bus.o_flush_busy), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Same-cycle allocate and lookup
        bus.i_lkp_vld = 1'b1; bus.i_lkp_pc = 32'h0000_1000;
        do_alloc(32'h0000_1000, 32'h0000_7000, 1'b0);
        bus.i_lkp_vld = 1'b0;
`ifdef BTB_SA_BYPASS_EN
        check_eq("same_cycle_hit", 64'(bus.o_rsp_hit), 64'd1);
`else
        check_eq("same_cycle_hit", 64'(bus.o_rsp_hit), 64'd0);
`endif
        do_lookup(32'h0000_1000);
        check_eq("next_cycle_hit", 64'(bus.o_rsp_hit), 64'd1);

        // Randomized traffic over a small tag pool to provoke hits and evictions
        for (int n = 0; n < 3000; n++) begin
            rp = {25'(32'h20 + $urandom_range(0, 5)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            bus.i_lkp_vld = ($urandom_range(0, 9) < 7);
            bus.i_lkp_pc  = rp;
            bus.i_new_vld = ($urandom_range(0, 9) < 3);
            bus.i_new_pc  = {25'(32'h20 + $urandom_range(0, 5)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            bus.i_new_taddr = $urandom;
            bus.i_new_type  = 1'($urandom_range(0, 1));
            bus.i_mis_vld   = ($urandom_range(0, 19) < 3);
            bus.i_mis_set   = 3'($urandom_range(0, 7));
            bus.i_mis_way   = 2'($urandom_range(0, 3));
            bus.i_mis_taddr = $urandom;
            bus.i_clr_vld   = ($urandom_range(0, 9) == 0);
            bus.i_clr_set   = 3'($urandom_range(0, 7));
            bus.i_clr_way   = 2'($urandom_range(0, 3));
            bus.i_flush     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/btb_sa_module.md
# btb_sa_module

Parametrised set-associative branch target buffer; the successor to the 32-entry fully-associative BTB in the BPU. It sits between the fetch PC generator (lookup port) and the branch resolution/commit logic (allocate, mispredict, clear ports). New behaviour over the previous generation:
- configurable sets and ways, with a registered one-cycle lookup;
- in-place update of an already-present branch, so no duplicate entries are created;
- per-set round-robin replacement;
- a multi-cycle whole-table flush sequencer.

## Interface
Parameters:
- PC_WIDTH, 32, PC and target address width
- SETS, 8, number of sets; power of two, ≥2; SET_BITS = log2(SETS)
- WAYS, 4, ways per set; power of two, ≥2; WAY_BITS = log2(WAYS)

Ports:
- clk  in  1  core clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- i_lkp_vld  in  1  lookup request
- i_lkp_pc  in  PC_WIDTH  fetch-block PC
- o_rsp_vld  out  1  lookup response valid
- o_rsp_hit  out  1  BTB hit
- o_rsp_set  out  SET_BITS  set of the hit entry
- o_rsp_way  out  WAY_BITS  way of the hit entry
- o_rsp_taddr  out  PC_WIDTH  predicted target
- o_rsp_offset  out  4  branch offset within the 16-byte fetch block
- o_rsp_type  out  1  branch type bit
- i_new_vld  in  1  allocate or refresh a branch
- i_new_pc, i_new_taddr  in  PC_WIDTH each  branch PC and target
- i_new_type  in  1  branch type
- i_mis_vld  in  1  target mispredict fix-up
- i_mis_set  in  SET_BITS  entry set for the fix-up
- i_mis_way  in  WAY_BITS  entry way for the fix-up
- i_mis_taddr  in  PC_WIDTH  corrected target
- i_clr_vld  in  1  invalidate one entry
- i_clr_set  in  SET_BITS  set of the entry to invalidate
- i_clr_way  in  WAY_BITS  way of the entry to invalidate
- i_flush  in  1  start a whole-table flush
- o_flush_busy  out  1  flush in progress

## Operation
Address split:
- offset = pc[3:0]
- set = pc[4+SET_BITS-1:4]
- tag = pc[PC_WIDTH-1:4+SET_BITS]

Each entry holds: valid, tag, taddr, offset, type.

Lookup:
- All ways of the indexed set are compared.
- Hit = a valid entry whose tag matches.
- On a miss, o_rsp_hit, set, way, taddr, offset and type are all 0.

Allocate (i_new_vld):
- If the tag is already present in the set, that way is overwritten with taddr, offset and type. The round-robin pointer does not move.
- Otherwise, if any way is invalid, the lowest-index invalid way is written.
- Otherwise, the way named by the set's round-robin pointer is written, and the pointer then increments modulo WAYS.

Mispredict (i_mis_vld):
- Rewrites taddr only. Offset, type and tag are kept.
- Ignored if the target entry is invalid.

Clear (i_clr_vld): valid of the named entry goes to 0.

Same-cycle collisions on the same entry:
- clear beats allocate and mispredict;
- allocate beats mispredict.

Non-colliding operations in the same cycle all take effect.

Flush FSM has two states, IDLE and FLUSH:
- IDLE→FLUSH on i_flush; a set counter loads 0.
- In FLUSH, one set per cycle has all valids and its round-robin pointer cleared; the counter increments.
- FLUSH→IDLE after set SETS-1 is cleared.
- o_flush_busy = (state == FLUSH).
- While in FLUSH: i_flush, allocate, mispredict and clear are ignored, and lookups respond with a miss.

Reset: all valids 0, round-robin pointers 0, FSM IDLE, all outputs 0. Reset asserted mid-flush returns to IDLE immediately.

## Timing
- Lookup latency is 1 cycle: a request at cycle N responds at N+1. o_rsp_vld is i_lkp_vld registered; no back-pressure.
- Updates presented at cycle N are visible to lookups from cycle N+1.
- A lookup at cycle N sees table state before the cycle-N updates, unless BTB_SA_BYPASS_EN is defined.
- Flush: i_flush at N gives o_flush_busy high from N+1 through N+SETS inclusive. The first post-flush lookup is accepted at N+SETS+1.
- Tag and data state have no reset; only valids, pointers, FSM and outputs are reset.

## Configuration
BTB_SA_BYPASS_EN:
- Defined: an allocate or mispredict at cycle N whose set/tag (or set/way) matches the cycle-N lookup is forwarded, so the N+1 response reflects the new data and hit = 1. A same-cycle clear of the matching entry forces a miss.
- Undefined: no forwarding; the response reflects pre-update state.

## Test plan
- Reset, then lookup PC 0x1000 → at N+1: o_rsp_vld=1, o_rsp_hit=0, all data outputs 0.
- Allocate PC 0x1004, taddr 0x2000, type 1; lookup 0x1000 two cycles later → hit=1, taddr=0x2000, offset=4, type=1, way=0.
- Fill set 0 with WAYS distinct tags, then allocate three more tags → replacements go to ways 0, 1, 2. Re-allocating an existing tag replaces in place, with no duplicate and no pointer move.
- Mispredict the 0x1004 entry with taddr 0x3000, and in the same cycle clear a different entry → lookup of 0x1000 gives taddr 0x3000, offset 4; the cleared entry misses.
- i_flush with SETS=8 → busy for exactly 8 cycles; allocates during busy are dropped; all lookups after busy miss. Assert rst_n mid-flush → busy=0 on the next edge.
- Same-cycle allocate and lookup of 0x1000 → response hit=1 with BTB_SA_BYPASS_EN defined, hit=0 without it.
